fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param_pkg.sv | 21 ++
 rtl/register_r_en.sv | 18 +
 rtl/fifo_param.sv | 125 ++++++++++++
 tb/tb_fifo_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_param_pkg.sv
// Shared constants for the parameterised FIFO: FSM state encodings and a
// constant clog2 used to size pointers and the occupancy counter.
package fifo_param_pkg;

  // State reflects the operation performed in the previous cycle
  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_NO_OP    = 3'd1;
  localparam logic [2:0] ST_WRITE    = 3'd2;
  localparam logic [2:0] ST_WR_ERROR = 3'd3;
  localparam logic [2:0] ST_READ     = 3'd4;
  localparam logic [2:0] ST_RD_ERROR = 3'd5;

  // Ceiling log2, usable in parameter/port declarations
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/register_r_en.sv
// One FIFO storage entry: WIDTH-bit register, async active-low reset, load enable.
module register_r_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when this entry is the write target
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with registered read data, occupancy count,
// status flags and registered ack/err handshake pulses.
// Optional feature macro: FIFO_PARAM_ALMOST_FLAGS_EN enables almost_full /
// almost_empty; without it both ports are tied low.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [WIDTH-1:0]      d_in,
  output logic [WIDTH-1:0]      d_out,
  output logic [clog2(DEPTH):0] data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  // Thresholds outside 0..DEPTH can never be meaningful
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_level
    $error("fifo_param: AF_LEVEL/AE_LEVEL outside 0..DEPTH");
  end

  logic [AW-1:0]                head, tail;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic [WIDTH-1:0]             rd_data;
  logic                         wr_ok, rd_ok;
  logic [2:0]                   state, state_nxt;
  // side[0]: the other direction was acked too, side[1]: the other direction erred
  logic [1:0]                   side, side_nxt;

  assign full  = (data_count == CW'(DEPTH));
  assign empty = (data_count == '0);

`ifdef FIFO_PARAM_ALMOST_FLAGS_EN
  assign almost_full  = (data_count >= CW'(AF_LEVEL));
  assign almost_empty = (data_count <= CW'(AE_LEVEL));
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

  // A rejected request never touches storage, pointers or count
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Storage: one register per entry, loaded only when tail points at it
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    register_r_en #(.WIDTH(WIDTH)) u_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (wr_ok && (tail == AW'(i))),
      .d       (d_in),
      .q       (mem[i])
    );
  end

  assign rd_data = mem[head];

  // Pointers, occupancy and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      d_out      <= '0;
    end else begin
      if (wr_ok) tail <= tail + 1'b1;
      if (rd_ok) begin
        head  <= head + 1'b1;
        d_out <= rd_data;
      end
      data_count <= data_count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      side  <= '0;
    end else begin
      state <= state_nxt;
      side  <= side_nxt;
    end
  end

  // Next state: a dual request lands in READ unless the FIFO was empty
  always_comb begin
    state_nxt = ST_NO_OP;
    side_nxt  = 2'b00;
    case ({wr_en, rd_en})
      2'b10: state_nxt = full  ? ST_WR_ERROR : ST_WRITE;
      2'b01: state_nxt = empty ? ST_RD_ERROR : ST_READ;
      2'b11: begin
        state_nxt = empty ? ST_WRITE : ST_READ;
        side_nxt  = (empty || full) ? 2'b10 : 2'b01;
      end
      default: state_nxt = ST_NO_OP;
    endcase
  end

  // Handshake pulses decoded from registered state; exclusive per direction
  always_comb begin
    wr_ack = (state == ST_WRITE)    | ((state == ST_READ)  & side[0]);
    wr_err = (state == ST_WR_ERROR) | ((state == ST_READ)  & side[1]);
    rd_ack = (state == ST_READ);
    rd_err = (state == ST_RD_ERROR) | ((state == ST_WRITE) & side[1]);
  end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (WIDTH=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1).
// A queue-based model tracks expected outputs; directed phases pin literal values.
module tb_fifo_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] d_in = '0;
  logic [WIDTH-1:0] d_out;
  logic [3:0]       data_count;
  logic             full, empty, almost_full, almost_empty;
  logic             wr_ack, wr_err, rd_ack, rd_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .d_in         (d_in),
    .d_out        (d_out),
    .data_count   (data_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a queue of words plus last-cycle outcome
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic m_wack = 0, m_werr = 0, m_rack = 0, m_rerr = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_dout = '0;
      m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
    end else begin
      bit wok, rok;
      wok = wr_en && (mq.size() < DEPTH);
      rok = rd_en && (mq.size() > 0);
      m_wack = wok; m_werr = wr_en && !wok;
      m_rack = rok; m_rerr = rd_en && !rok;
      if (rok) m_dout = mq.pop_front();
      if (wok) mq.push_back(d_in);
    end
  end

  // Compare every output against the model, away from the active edge
  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("data_count", data_count, n);
    chk("full", full, n == DEPTH);
    chk("empty", empty, n == 0);
    chk("d_out", d_out, m_dout);
    chk("wr_ack", wr_ack, m_wack);
    chk("wr_err", wr_err, m_werr);
    chk("rd_ack", rd_ack, m_rack);
    chk("rd_err", rd_err, m_rerr);
`ifdef FIFO_PARAM_ALMOST_FLAGS_EN
    chk("almost_full", almost_full, n >= 6);
    chk("almost_empty", almost_empty, n <= 1);
`else
    chk("almost_full", almost_full, 1'b0);
    chk("almost_empty", almost_empty, 1'b0);
`endif
  end

  // One operation: drive at negedge, return just after the capturing edge
  task automatic op(input logic w, input logic r, input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; d_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_count", data_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", d_out, 0);
    chk("rst_pulses", {wr_ack, wr_err, rd_ack, rd_err}, 4'b0000);
`ifdef FIFO_PARAM_ALMOST_FLAGS_EN
    chk("rst_ae", almost_empty, 1);
`else
    chk("rst_ae_off", almost_empty, 0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Fill 0x11..0x88, then overflow with 0x99
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 32'(i + 1) * 32'h11);
      chk("fill_count", data_count, i + 1);
      chk("fill_ack", wr_ack, 1);
`ifdef FIFO_PARAM_ALMOST_FLAGS_EN
      chk("fill_af", almost_full, (i + 1) >= 6);
`else
      chk("fill_af_off", almost_full, 0);
`endif
    end
    chk("full_after_8", full, 1);
    op(1, 0, 32'h99);
    chk("ovf_err", wr_err, 1);
    chk("ovf_ack", wr_ack, 0);
    chk("ovf_count", data_count, 8);

    // Drain in order, then underflow
    for (int i = 0; i < 8; i++) begin
      op(0, 1, '0);
      chk("drain_dout", d_out, 32'(i + 1) * 32'h11);
      chk("drain_ack", rd_ack, 1);
    end
    op(0, 1, '0);
    chk("unf_err", rd_err, 1);
    chk("unf_empty", empty, 1);
    chk("unf_dout_hold", d_out, 32'h88);

    // Both high while empty: write only, no write-through
    op(1, 1, 32'hA5);
    chk("be_pulses", {wr_ack, wr_err, rd_ack, rd_err}, 4'b1001);
    chk("be_count", data_count, 1);
    chk("be_dout", d_out, 32'h88);
    for (int i = 0; i < 7; i++) op(1, 0, 32'h20 + 32'(i));
    chk("bf_full", full, 1);
    // Both high while full: read only
    op(1, 1, 32'h5A);
    chk("bf_pulses", {wr_ack, wr_err, rd_ack, rd_err}, 4'b0110);
    chk("bf_count", data_count, 7);
    chk("bf_dout", d_out, 32'hA5);

    // Down to 3 entries (0x24..0x26), then 10 simultaneous cycles
    for (int i = 0; i < 4; i++) op(0, 1, '0);
    chk("sim_start", data_count, 3);
    for (int k = 0; k < 10; k++) begin
      op(1, 1, 32'h100 + 32'(k));
      chk("sim_count", data_count, 3);
      chk("sim_acks", {wr_ack, rd_ack}, 2'b11);
      chk("sim_dout", d_out, (k < 3) ? 32'h24 + 32'(k) : 32'h100 + 32'(k - 3));
    end

    // Random traffic, alternating write-heavy and read-heavy blocks
    for (int b = 0; b < 6; b++) begin
      int pw;
      pw = (b % 2 == 0) ? 75 : 25;
      for (int c = 0; c < 80; c++)
        op($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), $urandom);
    end

    // Asynchronous reset in the middle of a write stream
    op(1, 0, 32'hC1);
    op(0, 1, '0);
    @(negedge clk);
    wr_en = 1; rd_en = 0; d_in = 32'hC2;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_count", data_count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_dout", d_out, 0);
    chk("arst_wack", wr_ack, 0);
    @(negedge clk);
    wr_en = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // First operations after reset
    op(1, 0, 32'hD7);
    chk("post_count", data_count, 1);
    chk("post_wack", wr_ack, 1);
    op(0, 1, '0);
    chk("post_dout", d_out, 32'hD7);
    op(0, 0, '0);
    chk("post_idle", {wr_ack, wr_err, rd_ack, rd_err}, 4'b0000);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
